rename_map_table: RTL and testbench

//  Superscalar register alias table: speculative RAT, committed RRAT and circular branch-checkpoint store in one block.

---
 rtl/rename_map_table_pkg.sv | 27 ++
 rtl/rename_map_table_ckpt_store.sv | 92 +++++++++
 rtl/rename_map_table.sv | 131 +++++++++++++
 tb/tb_rename_map_table.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rename_map_table_pkg.sv
// Shared types and default sizes for the register alias table.
//   NUM_ARCH_REGS / NUM_PHYS_REGS : register file sizes
//   RENAME_WIDTH / COMMIT_WIDTH   : lanes per cycle
//   NUM_CKPTS                     : branch checkpoint slots (power of 2)
package rename_map_table_pkg;

    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned NUM_PHYS_REGS = 128;
    localparam int unsigned RENAME_WIDTH  = 2;
    localparam int unsigned COMMIT_WIDTH  = 2;
    localparam int unsigned NUM_CKPTS     = 4;

    localparam int unsigned AW = $clog2(NUM_ARCH_REGS);
    localparam int unsigned PW = $clog2(NUM_PHYS_REGS);
    localparam int unsigned CW = $clog2(NUM_CKPTS);

    typedef logic [CW-1:0] ckpt_id_t;
    typedef logic [AW-1:0] arch_reg_t;
    typedef logic [PW-1:0] phys_reg_t;
    typedef phys_reg_t [NUM_ARCH_REGS-1:0] map_t;

    typedef enum logic [0:0] {
        StRun,
        StRecover
    } rat_state_e;

endpackage

// File: rtl/rename_map_table_ckpt_store.sv
// Circular store of map snapshots taken at branch boundaries.
//   clk, rst        : clock, synchronous active-low reset
//   wr_en, wr_map   : push a snapshot at tail
//   free_en         : release the head slot (ignored when empty)
//   restore_en/_id  : roll back to a slot; it and younger slots are dropped
//   flush           : drop every slot
//   rd_map          : snapshot held in slot restore_id
//   tail, full      : next slot id to be allocated, all slots live
module rename_map_table_ckpt_store
    import rename_map_table_pkg::*;
#(
    parameter int unsigned NUM_ARCH_REGS = rename_map_table_pkg::NUM_ARCH_REGS,
    parameter int unsigned NUM_PHYS_REGS = rename_map_table_pkg::NUM_PHYS_REGS,
    parameter int unsigned NUM_CKPTS     = rename_map_table_pkg::NUM_CKPTS,
    localparam int unsigned PW = $clog2(NUM_PHYS_REGS),
    localparam int unsigned CW = $clog2(NUM_CKPTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [NUM_ARCH_REGS-1:0][PW-1:0]    wr_map,
    input  logic                                free_en,
    input  logic                                restore_en,
    input  logic [CW-1:0]                       restore_id,
    input  logic                                flush,
    output logic [NUM_ARCH_REGS-1:0][PW-1:0]    rd_map,
    output logic [CW-1:0]                       tail,
    output logic                                full
);

    logic [NUM_CKPTS-1:0][NUM_ARCH_REGS-1:0][PW-1:0] snap_q;
    logic [CW-1:0] head_q, head_d, tail_q, tail_d, head_nf;
    logic [CW:0]   count_q, count_d;
    logic          free_ok;

    assign rd_map = snap_q[restore_id];
    assign tail   = tail_q;
    assign full   = (count_q == (CW+1)'(NUM_CKPTS));

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        free_ok = free_en && (count_q != '0);
        head_nf = free_ok ? head_q + CW'(1) : head_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (restore_en) begin
            tail_d = restore_id;
            if (free_ok && (restore_id == head_q)) begin
                // Freed and restored slot coincide: nothing younger survives.
                head_d  = restore_id;
                count_d = '0;
            end else begin
                head_d  = head_nf;
                count_d = {1'b0, CW'(restore_id - head_nf)};
            end
        end else begin
            head_d  = head_nf;
            count_d = count_q - {{CW{1'b0}}, free_ok} + {{CW{1'b0}}, wr_en};
            if (wr_en) begin
                tail_d = tail_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Snapshot contents need no reset; a slot is only read after being written.
    always_ff @(posedge clk) begin
        if (rst && !flush && !restore_en && wr_en) begin
            snap_q[tail_q] <= wr_map;
        end
    end

    // Restoring a slot that is not live is a protocol error upstream.
    a_restore_live : assert property (@(posedge clk) disable iff (!rst)
        (restore_en && !flush) |-> ({1'b0, CW'(restore_id - head_q)} < count_q));

endmodule

// File: rtl/rename_map_table.sv
// Speculative RAT, committed RRAT and branch checkpoints.
//   clk, rst                       : clock, synchronous active-low reset
//   rn_*                           : rename group in, renamed sources / old dst out
//   rn_ckpt_i, rn_ckpt_id_o        : snapshot request and the slot it gets
//   ckpt_full_o, ckpt_free_i       : checkpoint occupancy and head release
//   ckpt_restore_i/_id_i           : mispredict rollback
//   cm_*                           : retiring mappings into the RRAT
//   flush_i                        : RAT <- RRAT (with this cycle's commits)
module rename_map_table
    import rename_map_table_pkg::*;
#(
    parameter int unsigned NUM_ARCH_REGS = rename_map_table_pkg::NUM_ARCH_REGS,
    parameter int unsigned NUM_PHYS_REGS = rename_map_table_pkg::NUM_PHYS_REGS,
    parameter int unsigned RENAME_WIDTH  = rename_map_table_pkg::RENAME_WIDTH,
    parameter int unsigned COMMIT_WIDTH  = rename_map_table_pkg::COMMIT_WIDTH,
    parameter int unsigned NUM_CKPTS     = rename_map_table_pkg::NUM_CKPTS,
    localparam int unsigned AW = $clog2(NUM_ARCH_REGS),
    localparam int unsigned PW = $clog2(NUM_PHYS_REGS),
    localparam int unsigned CW = $clog2(NUM_CKPTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [RENAME_WIDTH-1:0]             rn_valid_i,
    input  logic [RENAME_WIDTH-1:0][AW-1:0]     rn_src1_arch_i,
    input  logic [RENAME_WIDTH-1:0][AW-1:0]     rn_src2_arch_i,
    input  logic [RENAME_WIDTH-1:0]             rn_dst_we_i,
    input  logic [RENAME_WIDTH-1:0][AW-1:0]     rn_dst_arch_i,
    input  logic [RENAME_WIDTH-1:0][PW-1:0]     rn_dst_phys_i,
    input  logic                                rn_ckpt_i,
    output logic                                rn_ready_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]     rn_src1_phys_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]     rn_src2_phys_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]     rn_old_phys_o,
    output logic [CW-1:0]                       rn_ckpt_id_o,
    output logic                                ckpt_full_o,
    input  logic                                ckpt_free_i,
    input  logic                                ckpt_restore_i,
    input  logic [CW-1:0]                       ckpt_restore_id_i,
    input  logic [COMMIT_WIDTH-1:0]             cm_valid_i,
    input  logic [COMMIT_WIDTH-1:0][AW-1:0]     cm_arch_i,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]     cm_phys_i,
    input  logic                                flush_i
);

    logic [NUM_ARCH_REGS-1:0][PW-1:0] rat_q, rat_d, rrat_q, rrat_d, rat_post, snap_map;
    rat_state_e state_q, state_d;
    logic       fire;

    assign rn_ready_o = (state_q == StRun) && !flush_i && !ckpt_restore_i &&
                        !(rn_ckpt_i && ckpt_full_o);
    assign fire       = (|rn_valid_i) && rn_ready_o;

    // Lookup with intra-group bypass: later older lanes override earlier ones,
    // so the youngest matching older lane wins.
    always_comb begin
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            rn_src1_phys_o[j] = rat_q[rn_src1_arch_i[j]];
            rn_src2_phys_o[j] = rat_q[rn_src2_arch_i[j]];
            rn_old_phys_o[j]  = rat_q[rn_dst_arch_i[j]];
            for (int i = 0; i < j; i++) begin
                if (rn_valid_i[i] && rn_dst_we_i[i]) begin
                    if (rn_dst_arch_i[i] == rn_src1_arch_i[j]) rn_src1_phys_o[j] = rn_dst_phys_i[i];
                    if (rn_dst_arch_i[i] == rn_src2_arch_i[j]) rn_src2_phys_o[j] = rn_dst_phys_i[i];
                    if (rn_dst_arch_i[i] == rn_dst_arch_i[j])  rn_old_phys_o[j]  = rn_dst_phys_i[i];
                end
            end
        end
    end

    // Post-group map; ascending lane order makes the highest lane win.
    always_comb begin
        rat_post = rat_q;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (rn_valid_i[i] && rn_dst_we_i[i]) rat_post[rn_dst_arch_i[i]] = rn_dst_phys_i[i];
        end
    end

    always_comb begin
        rrat_d = rrat_q;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (cm_valid_i[k]) rrat_d[cm_arch_i[k]] = cm_phys_i[k];
        end
    end

    always_comb begin
        rat_d   = rat_q;
        state_d = StRun;
        if (flush_i) begin
            rat_d   = rrat_d;
            state_d = StRecover;
        end else if (ckpt_restore_i) begin
            rat_d   = snap_map;
            state_d = StRecover;
        end else if (fire) begin
            rat_d   = rat_post;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                rat_q[i]  <= PW'(i);
                rrat_q[i] <= PW'(i);
            end
            state_q <= StRun;
        end else begin
            rat_q   <= rat_d;
            rrat_q  <= rrat_d;
            state_q <= state_d;
        end
    end

    rename_map_table_ckpt_store #(
        .NUM_ARCH_REGS (NUM_ARCH_REGS),
        .NUM_PHYS_REGS (NUM_PHYS_REGS),
        .NUM_CKPTS     (NUM_CKPTS)
    ) u_ckpt_store (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (fire && rn_ckpt_i),
        .wr_map     (rat_post),
        .free_en    (ckpt_free_i),
        .restore_en (ckpt_restore_i),
        .restore_id (ckpt_restore_id_i),
        .flush      (flush_i),
        .rd_map     (snap_map),
        .tail       (rn_ckpt_id_o),
        .full       (ckpt_full_o)
    );

endmodule

// File: tb/tb_rename_map_table.sv
module tb_rename_map_table;
    import rename_map_table_pkg::*;

    localparam int unsigned RW  = RENAME_WIDTH;
    localparam int unsigned CMW = COMMIT_WIDTH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [RW-1:0]          rn_valid_i;
    logic [RW-1:0][AW-1:0]  rn_src1_arch_i, rn_src2_arch_i, rn_dst_arch_i;
    logic [RW-1:0]          rn_dst_we_i;
    logic [RW-1:0][PW-1:0]  rn_dst_phys_i;
    logic                   rn_ckpt_i;
    logic                   rn_ready_o;
    logic [RW-1:0][PW-1:0]  rn_src1_phys_o, rn_src2_phys_o, rn_old_phys_o;
    logic [CW-1:0]          rn_ckpt_id_o;
    logic                   ckpt_full_o;
    logic                   ckpt_free_i, ckpt_restore_i;
    logic [CW-1:0]          ckpt_restore_id_i;
    logic [CMW-1:0]         cm_valid_i;
    logic [CMW-1:0][AW-1:0] cm_arch_i;
    logic [CMW-1:0][PW-1:0] cm_phys_i;
    logic                   flush_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rename_map_table dut (
        .clk               (clk),
        .rst               (rst),
        .rn_valid_i        (rn_valid_i),
        .rn_src1_arch_i    (rn_src1_arch_i),
        .rn_src2_arch_i    (rn_src2_arch_i),
        .rn_dst_we_i       (rn_dst_we_i),
        .rn_dst_arch_i     (rn_dst_arch_i),
        .rn_dst_phys_i     (rn_dst_phys_i),
        .rn_ckpt_i         (rn_ckpt_i),
        .rn_ready_o        (rn_ready_o),
        .rn_src1_phys_o    (rn_src1_phys_o),
        .rn_src2_phys_o    (rn_src2_phys_o),
        .rn_old_phys_o     (rn_old_phys_o),
        .rn_ckpt_id_o      (rn_ckpt_id_o),
        .ckpt_full_o       (ckpt_full_o),
        .ckpt_free_i       (ckpt_free_i),
        .ckpt_restore_i    (ckpt_restore_i),
        .ckpt_restore_id_i (ckpt_restore_id_i),
        .cm_valid_i        (cm_valid_i),
        .cm_arch_i         (cm_arch_i),
        .cm_phys_i         (cm_phys_i),
        .flush_i           (flush_i)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        rn_valid_i        = '0;
        rn_src1_arch_i    = '0;
        rn_src2_arch_i    = '0;
        rn_dst_we_i       = '0;
        rn_dst_arch_i     = '0;
        rn_dst_phys_i     = '0;
        rn_ckpt_i         = 1'b0;
        ckpt_free_i       = 1'b0;
        ckpt_restore_i    = 1'b0;
        ckpt_restore_id_i = '0;
        cm_valid_i        = '0;
        cm_arch_i         = '0;
        cm_phys_i         = '0;
        flush_i           = 1'b0;
    endtask

    // Clock edge, then move off it before anything is driven or sampled.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    // Reads the current map through lane 0's source-1 port with no rename active.
    task automatic lookup(input string tag, input int arch, input int exp);
        rn_src1_arch_i[0] = AW'(arch);
        #1;
        check(tag, int'(rn_src1_phys_o[0]), exp);
    endtask

    task automatic rename1(input int arch, input int phys, input logic ckpt);
        rn_valid_i[0]    = 1'b1;
        rn_dst_we_i[0]   = 1'b1;
        rn_dst_arch_i[0] = AW'(arch);
        rn_dst_phys_i[0] = PW'(phys);
        rn_ckpt_i        = ckpt;
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;

        // Reset state
        check("rst_ready", int'(rn_ready_o), 1);
        check("rst_full", int'(ckpt_full_o), 0);
        check("rst_ckpt_id", int'(rn_ckpt_id_o), 0);
        lookup("rst_r5", 5, 5);

        // 1: single rename then lookup
        rename1(3, 40, 1'b0);
        check("t1_old_phys", int'(rn_old_phys_o[0]), 3);
        step();
        lookup("t1_r3", 3, 40);

        // 2: intra-group bypass, highest lane wins
        rn_valid_i        = 2'b11;
        rn_dst_we_i       = 2'b11;
        rn_dst_arch_i[0]  = AW'(1);
        rn_dst_phys_i[0]  = PW'(50);
        rn_src1_arch_i[1] = AW'(1);
        rn_src2_arch_i[1] = AW'(3);
        rn_dst_arch_i[1]  = AW'(1);
        rn_dst_phys_i[1]  = PW'(51);
        #1;
        check("t2_l1_src1", int'(rn_src1_phys_o[1]), 50);
        check("t2_l1_src2", int'(rn_src2_phys_o[1]), 40);
        check("t2_l1_old", int'(rn_old_phys_o[1]), 50);
        check("t2_l0_old", int'(rn_old_phys_o[0]), 1);
        step();
        lookup("t2_r1", 1, 51);

        // 3: checkpoint, overwrite, restore
        rename1(2, 60, 1'b1);
        check("t3_ckpt_id", int'(rn_ckpt_id_o), 0);
        check("t3_ready", int'(rn_ready_o), 1);
        step();
        check("t3_tail", int'(rn_ckpt_id_o), 1);
        rename1(2, 61, 1'b0);
        step();
        lookup("t3_r2_spec", 2, 61);
        ckpt_restore_i    = 1'b1;
        ckpt_restore_id_i = '0;
        #1;
        check("t3_ready_restore", int'(rn_ready_o), 0);
        step();
        check("t3_ready_recover", int'(rn_ready_o), 0);
        lookup("t3_r2_restored", 2, 60);
        lookup("t3_r1_restored", 1, 51);
        check("t3_tail_restored", int'(rn_ckpt_id_o), 0);
        check("t3_full", int'(ckpt_full_o), 0);
        step();
        check("t3_ready_run", int'(rn_ready_o), 1);

        // 4: fill all checkpoint slots, stall, free, wrap-around allocate
        for (int k = 0; k < 4; k++) begin
            rename1(10, 100 + k, 1'b1);
            check($sformatf("t4_id%0d", k), int'(rn_ckpt_id_o), k);
            step();
        end
        check("t4_full", int'(ckpt_full_o), 1);
        rename1(11, 110, 1'b1);
        check("t4_stall", int'(rn_ready_o), 0);
        step();
        lookup("t4_r11_unchanged", 11, 11);
        lookup("t4_r10", 10, 103);
        ckpt_free_i = 1'b1;
        step();
        check("t4_full_after_free", int'(ckpt_full_o), 0);
        rename1(11, 110, 1'b1);
        check("t4_wrap_ready", int'(rn_ready_o), 1);
        check("t4_wrap_id", int'(rn_ckpt_id_o), 0);
        step();
        check("t4_full_again", int'(ckpt_full_o), 1);
        lookup("t4_r11", 11, 110);

        // 5: commit alongside flush is visible in the flushed map
        cm_valid_i[0] = 1'b1;
        cm_arch_i[0]  = AW'(7);
        cm_phys_i[0]  = PW'(70);
        flush_i       = 1'b1;
        #1;
        check("t5_ready_flush", int'(rn_ready_o), 0);
        step();
        lookup("t5_r7", 7, 70);
        lookup("t5_r3", 3, 3);
        lookup("t5_r10", 10, 10);
        check("t5_full", int'(ckpt_full_o), 0);
        check("t5_ckpt_id", int'(rn_ckpt_id_o), 0);
        check("t5_ready_recover", int'(rn_ready_o), 0);
        step();
        check("t5_ready_run", int'(rn_ready_o), 1);

        // 6: commit collision, then reset mid-recover
        cm_valid_i   = 2'b11;
        cm_arch_i[0] = AW'(9);
        cm_phys_i[0] = PW'(80);
        cm_arch_i[1] = AW'(9);
        cm_phys_i[1] = PW'(81);
        step();
        flush_i = 1'b1;
        step();
        lookup("t6_r9", 9, 81);
        lookup("t6_r7", 7, 70);
        check("t6_recover", int'(rn_ready_o), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_ready_after_rst", int'(rn_ready_o), 1);
        lookup("t6_r9_rst", 9, 9);
        lookup("t6_r7_rst", 7, 7);
        check("t6_ckpt_id_rst", int'(rn_ckpt_id_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
